// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared reaction-timer constants and debounce state encoding
package button_conditioner_pkg;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;

    // 10 ms of stability at a 50 MHz system clock
    localparam int DB_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_e;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// rtl/button_conditioner_debounce_channel.sv - one button: 2-flop synchroniser, debounce FSM, level and press tick
module button_conditioner_debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_tick
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync0_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync0_q <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync0_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    // Any opposite sample in a WAIT state aborts it; re-entry always reloads the full count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync0_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sync0_q) begin
                    state_d = ST_LOW;
                end else if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    level_d = 1'b1;
                    tick_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync0_q) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT_LOW: begin
                if (sync0_q) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    assign btn_level = level_q;
    assign btn_tick  = tick_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchronise and debounce front end for the reaction timer
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN     = BTN_CLEAR + 1,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_tick
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_conditioner_debounce_channel #(
            .DB_CYCLES(DB_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .btn_in   (btn_in[i]),
            .btn_level(btn_level[i]),
            .btn_tick (btn_tick[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner at DB_CYCLES 4 and 1
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] b4 = '0, b1 = '0;
    logic [2:0] l4, t4, l1, t1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_conditioner #(.N_BTN(3), .DB_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .btn_in(b4), .btn_level(l4), .btn_tick(t4));
    button_conditioner #(.N_BTN(3), .DB_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .btn_in(b1), .btn_level(l1), .btn_tick(t1));

    typedef struct packed {
        logic [2:0] l4, t4, l1, t1;
    } exp_t;
    exp_t expq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a level flips once DB+1 consecutive synchronised samples disagree with it.
    logic [2:0] ms1[2], ms0[2], mlv[2], mtk[2];
    int run[2][3];
    always @(posedge clk) begin
        exp_t e;
        int db;
        logic smp;
        for (int d = 0; d < 2; d++) begin
            mtk[d] = '0;
            if (reset) begin
                ms1[d] = '0; ms0[d] = '0; mlv[d] = '0;
                for (int c = 0; c < 3; c++) run[d][c] = 0;
            end else begin
                db = (d == 0) ? 4 : 1;
                for (int c = 0; c < 3; c++) begin
                    smp = ms0[d][c];
                    if (smp != mlv[d][c]) begin
                        run[d][c]++;
                        if (run[d][c] == db + 1) begin
                            mlv[d][c] = smp;
                            mtk[d][c] = smp;
                            run[d][c] = 0;
                        end
                    end else begin
                        run[d][c] = 0;
                    end
                end
                ms0[d] = ms1[d];
                ms1[d] = (d == 0) ? b4 : b1;
            end
        end
        e.l4 = mlv[0]; e.t4 = mtk[0]; e.l1 = mlv[1]; e.t1 = mtk[1];
        expq.push_back(e);
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = expq.pop_front();
            check("db4_level", l4, e.l4);
            check("db4_tick", t4, e.t4);
            check("db1_level", l1, e.l1);
            check("db1_tick", t1, e.t1);
        end
    end

    // Called right after driving at a negedge: iteration 0 is the first edge sampling the new input.
    task automatic measure(input int d, input int ch, input bit fall, input int exp_lat,
                           input int exp_ticks, input int win, input string nm,
                           output logic [2:0] tvec, output int drops);
        int lat = -1;
        int nt = 0;
        logic [2:0] lv, tk;
        tvec = '0;
        drops = 0;
        for (int n = 0; n < win; n++) begin
            @(posedge clk);
            #1;
            lv = (d == 0) ? l4 : l1;
            tk = (d == 0) ? t4 : t1;
            if (tk[ch]) nt++;
            if (lat >= 0 && !fall && !lv[ch]) drops++;
            if (lat < 0 && (fall ? !lv[ch] : tk[ch])) begin
                lat = n;
                tvec = tk;
            end
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_ticks"}, nt, exp_ticks);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [2:0] tv;
        int drops;
        int bt;
        logic [0:4] pat;

        idle(3);
        check("reset_db4_level", l4, 0);
        check("reset_db4_tick", t4, 0);
        check("reset_db1_level", l1, 0);
        reset = 1'b0;
        idle(2);

        b4[BTN_START] = 1'b1;
        measure(0, BTN_START, 1'b0, 6, 1, 20, "clean_press", tv, drops);
        check("clean_press_others", tv, 3'b001);
        check("clean_press_hold", drops, 0);
        b4 = '0;
        idle(20);

        pat = 5'b10110;
        bt = 0;
        for (int i = 0; i < 5; i++) begin
            b4[BTN_STOP] = pat[i];
            @(posedge clk);
            #1;
            if (t4[BTN_STOP] || l4[BTN_STOP]) bt++;
            @(negedge clk);
        end
        check("bounce_quiet", bt, 0);
        b4[BTN_STOP] = 1'b1;
        measure(0, BTN_STOP, 1'b0, 6, 1, 25, "bounce", tv, drops);

        b4[BTN_CLEAR] = 1'b1;
        measure(0, BTN_CLEAR, 1'b0, 6, 1, 15, "clear_press", tv, drops);
        b4[BTN_CLEAR] = 1'b0;
        measure(0, BTN_CLEAR, 1'b1, 6, 0, 10, "release", tv, drops);

        b4 = '0;
        idle(20);
        b4 = 3'b111;
        measure(0, BTN_START, 1'b0, 6, 1, 20, "simul", tv, drops);
        check("simul_vec", tv, 3'b111);

        b4 = '0;
        idle(20);
        b4[BTN_STOP] = 1'b1;
        idle(15);
        b4[BTN_START] = 1'b1;
        idle(4);
        reset = 1'b1;
        #1;
        check("async_reset_level", l4, 0);
        check("async_reset_tick", t4, 0);
        idle(2);
        reset = 1'b0;
        measure(0, BTN_START, 1'b0, 6, 1, 30, "reset_requal", tv, drops);
        check("reset_requal_vec", tv, 3'b011);

        b4 = '0;
        b1[BTN_START] = 1'b1;
        measure(1, BTN_START, 1'b0, 3, 1, 1000, "long_hold", tv, drops);
        check("long_hold_level", drops, 0);
        b1 = '0;
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                check("rand_async_reset", {l4, t4, l1, t1}, 0);
            end
            if ($urandom_range(0, 7) == 0) b4 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) b1 = 3'($urandom);
            @(negedge clk);
        end

        reset = 1'b0;
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
